muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that extends the combinational ALU with the MIPS MULT/MULTU/DIV/DIVU operations and HI/LO result registers. It runs multi-cycle: one shift-add or shift-subtract step per clock. It uses a start/busy/done handshake so the datapath controller stalls while the unit is busy. It sits beside the ALU in the execute stage, and its HI/LO outputs feed the MFHI/MFLO result mux.

---
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Interface bundle between the execute-stage controller and muldiv_unit.
//   start, op, a, b   : launch request with operation code and operands
//   hi_we, lo_we      : MTHI / MTLO write enables, data on wdata
//   busy, done        : operation in progress / one-cycle completion pulse
//   divzero           : last completed operation was a divide by zero
//   hi, lo            : architectural HI/LO registers
// master = controller side, slave = muldiv_unit side.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers. One shift-add
// (multiply) or restoring shift-subtract (divide) step per clock on operand
// magnitudes, followed by a sign-correction cycle that commits HI/LO.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : muldiv_unit_if slave modport (start/op/a/b, hi_we/lo_we/wdata,
//            busy/done/divzero, hi/lo)
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Two's-complement negation when en is set (WIDTH and 2*WIDTH variants).
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;       // product high half / partial remainder
    logic [WIDTH-1:0] wq_q, wq_d;         // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] m_q, m_d;           // |multiplicand| or |divisor|
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;       // result (product/quotient) is negative
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;         // divisor captured as zero
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    // Operand sign decode and magnitudes; |most-negative| wraps to 2^(WIDTH-1),
    // which is the correct unsigned magnitude.
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    a_neg, b_neg;
    logic [WIDTH-1:0]        a_mag, b_mag;

    assign a_s   = bus.a;
    assign b_s   = bus.b;
    assign a_neg = bus.op[0] & (a_s < 0);
    assign b_neg = bus.op[0] & (b_s < 0);
    assign a_mag = cond_neg_w(bus.a, a_neg);
    assign b_mag = cond_neg_w(bus.b, b_neg);

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    assign add_sum = {1'b0, acc_q} + {1'b0, m_q};
    assign shifted = {acc_q, wq_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, m_q};
    assign prod    = cond_neg_2w({acc_q, wq_q}, neg_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wq_d      = wq_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        a_orig_d  = a_orig_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = (bus.b == '0);
                    a_orig_d  = bus.a;
                    cnt_d     = '0;
                    acc_d     = '0;
                    wq_d      = bus.op[1] ? a_mag : b_mag;
                    m_d       = bus.op[1] ? b_mag : a_mag;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        wq_d  = {wq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        wq_d  = {wq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add: product forms in {acc, wq} as multiplier bits retire.
                    if (wq_q[0]) begin
                        acc_d = add_sum[WIDTH:1];
                        wq_d  = {add_sum[0], wq_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[WIDTH-1:1]};
                        wq_d  = {acc_q[0], wq_q[WIDTH-1:1]};
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = cond_neg_w(acc_q, rem_neg_q);
                    lo_d = cond_neg_w(wq_q, neg_q);
                end
                divzero_d = is_div_q & dz_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            wq_q      <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            a_orig_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wq_q      <= wq_d;
            m_q       <= m_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            a_orig_q  <= a_orig_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (WIDTH=32): reset state, MULTU/MULT/DIV/DIVU
// results, divide by zero, signed overflow, start/MTHI ignored while busy,
// MTLO after completion, back-to-back start on done, asynchronous abort.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for done; counts busy cycles seen at negedges.
    task automatic wait_done(output int busy_cycles, output bit saw_done);
        busy_cycles = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                saw_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge where done=1.
    task automatic launch_and_wait(input logic [1:0] op_i, input logic [31:0] a_i,
                                   input logic [31:0] b_i, output int busy_cycles,
                                   output bit saw_done);
        bus.start = 1'b1;
        bus.op = op_i;
        bus.a = a_i;
        bus.b = b_i;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(busy_cycles, saw_done);
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else passed++;
        total++; if (bus.divzero !== 1'b0) $display("FAIL reset_divzero got %0b want 0", bus.divzero); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int cyc; bit ok;
        launch_and_wait(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL multu_done_timeout got %0b want 1", ok); else passed++;
        total++; if (cyc != 33) $display("FAIL multu_busy_cycles got %0d want 33", cyc); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else passed++;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) $display("FAIL multu_done_pulse got %0b want 0", bus.done); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL multu_idle_busy got %0b want 0", bus.busy); else passed++;
    endtask

    // MULT then DIV launched in the very cycle done is high.
    task automatic test_back_to_back_signed();
        int cyc; bit ok;
        launch_and_wait(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL mult_done_timeout got %0b want 1", ok); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo got %h want ffffffeb", bus.lo); else passed++;
        launch_and_wait(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL div_done_timeout got %0b want 1", ok); else passed++;
        total++; if (cyc != 33) $display("FAIL div_busy_cycles got %0d want 33", cyc); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", bus.hi); else passed++;
        total++; if (bus.divzero !== 1'b0) $display("FAIL div_divzero got %0b want 0", bus.divzero); else passed++;
        @(negedge clk);
    endtask

    task automatic test_divzero();
        int cyc; bit ok;
        launch_and_wait(2'b10, 32'd100, 32'd0, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL dz_done_timeout got %0b want 1", ok); else passed++;
        total++; if (cyc != 33) $display("FAIL dz_busy_cycles got %0d want 33", cyc); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo got %h want ffffffff", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0000_0064) $display("FAIL dz_hi got %h want 00000064", bus.hi); else passed++;
        total++; if (bus.divzero !== 1'b1) $display("FAIL dz_flag got %0b want 1", bus.divzero); else passed++;
        @(negedge clk);
        total++; if (bus.divzero !== 1'b1) $display("FAIL dz_flag_hold got %0b want 1", bus.divzero); else passed++;
        launch_and_wait(2'b10, 32'd100, 32'd7, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL divu_done_timeout got %0b want 1", ok); else passed++;
        total++; if (bus.lo !== 32'd14) $display("FAIL divu_lo got %h want 0000000e", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd2) $display("FAIL divu_hi got %h want 00000002", bus.hi); else passed++;
        total++; if (bus.divzero !== 1'b0) $display("FAIL divu_divzero got %0b want 0", bus.divzero); else passed++;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int cyc; bit ok;
        launch_and_wait(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL ovf_done_timeout got %0b want 1", ok); else passed++;
        total++; if (bus.lo !== 32'h8000_0000) $display("FAIL ovf_lo got %h want 80000000", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0000_0000) $display("FAIL ovf_hi got %h want 00000000", bus.hi); else passed++;
        total++; if (bus.divzero !== 1'b0) $display("FAIL ovf_divzero got %0b want 0", bus.divzero); else passed++;
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cyc; bit ok;
        bus.hi_we = 1'b1; bus.wdata = 32'h1111_1111;
        @(negedge clk);
        bus.hi_we = 1'b0;
        total++; if (bus.hi !== 32'h1111_1111) $display("FAIL mthi got %h want 11111111", bus.hi); else passed++;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd50; bus.b = 32'd0;
        bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        total++; if (bus.hi !== 32'h1111_1111) $display("FAIL busy_hi_hold got %h want 11111111", bus.hi); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL busy_mid got %0b want 1", bus.busy); else passed++;
        wait_done(cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL ign_done_timeout got %0b want 1", ok); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL ign_hi got %h want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd15) $display("FAIL ign_lo got %h want 0000000f", bus.lo); else passed++;
        total++; if (bus.divzero !== 1'b0) $display("FAIL ign_divzero got %0b want 0", bus.divzero); else passed++;
        bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        total++; if (bus.lo !== 32'h1234_5678) $display("FAIL mtlo got %h want 12345678", bus.lo); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL no_queued_start got %0b want 0", bus.busy); else passed++;
    endtask

    task automatic test_async_reset();
        int cyc; bit ok;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL arst_busy got %0b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL arst_done got %0b want 0", bus.done); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL arst_hi got %h want 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL arst_lo got %h want 0", bus.lo); else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        launch_and_wait(2'b00, 32'd7, 32'd9, cyc, ok);
        total++; if (ok !== 1'b1) $display("FAIL rerun_done_timeout got %0b want 1", ok); else passed++;
        total++; if (cyc != 33) $display("FAIL rerun_busy_cycles got %0d want 33", cyc); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL rerun_hi got %h want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd63) $display("FAIL rerun_lo got %h want 0000003f", bus.lo); else passed++;
    endtask

    initial begin
        test_reset();
        test_multu();
        test_back_to_back_signed();
        test_divzero();
        test_overflow();
        test_busy_ignore();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
